// File: rtl/mul_sequencer.sv
// mul_sequencer: RV64 multiply sequencer that builds a 64x64 product from up to four
// 32x32 partial products on a shared external unsigned multiplier (1-cycle latency).
module mul_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic [2:0]  op_i,
   input  logic [63:0] a_i,
   input  logic [63:0] b_i,
   input  logic        flush,
   output logic        ready_o,
   output logic        done_o,
   output logic [63:0] c_o,
   output logic [31:0] m_a,
   output logic [31:0] m_b,
   input  logic [63:0] m_p
);

   localparam logic [2:0] OpMul    = 3'd0;
   localparam logic [2:0] OpMulh   = 3'd1;
   localparam logic [2:0] OpMulhsu = 3'd2;
   localparam logic [2:0] OpMulhu  = 3'd3;
   localparam logic [2:0] OpMulw   = 3'd4;

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e       state_q, state_d;
   logic [1:0]   slot_q, slot_d;
   logic [2:0]   op_q, op_d;
   logic         sign_q, sign_d;
   logic [63:0]  amag_q, amag_d;
   logic [63:0]  bmag_q, bmag_d;
   logic [127:0] acc_q, acc_d;
   logic         pend_q, pend_d;
   logic [1:0]   pend_slot_q, pend_slot_d;
   logic [63:0]  c_q, c_d;

   logic         accept;
   logic         a_signed, b_signed, a_neg, b_neg;
   logic [63:0]  a_mag, b_mag;
   logic [1:0]   last_slot;
   logic         issuing;
   logic [6:0]   shamt;
   logic [127:0] addend;
   logic [127:0] prod;
   logic [63:0]  res;

   assign ready_o = (state_q == StIdle) || (state_q == StDone);
   assign accept  = valid_i && ready_o && !flush;

   // Operand signedness and magnitudes from the incoming request
   always_comb begin
      a_signed = (op_i == OpMulh) || (op_i == OpMulhsu);
      b_signed = (op_i == OpMulh);
      a_neg    = a_signed && a_i[63];
      b_neg    = b_signed && b_i[63];
      a_mag    = a_neg ? (~a_i + 64'd1) : a_i;
      b_mag    = b_neg ? (~b_i + 64'd1) : b_i;
   end

   // Slot plan per op; MULW keeps one idle slot so its latency stays at four cycles.
   // Reserved ops run four idle slots and produce zero.
   always_comb begin
      last_slot = 2'd3;
      issuing   = 1'b0;
      if (op_q == OpMul) begin
         last_slot = 2'd2;
      end else if (op_q == OpMulw) begin
         last_slot = 2'd1;
      end
      if (state_q == StIssue) begin
         if (op_q == OpMulw) begin
            issuing = (slot_q == 2'd0);
         end else begin
            issuing = (op_q <= OpMulhu);
         end
      end
   end

   // Multiplier operand select; zero whenever no partial product is issued
   always_comb begin
      m_a = 32'd0;
      m_b = 32'd0;
      if (issuing) begin
         unique case (slot_q)
            2'd0: begin m_a = amag_q[31:0];  m_b = bmag_q[31:0];  end
            2'd1: begin m_a = amag_q[63:32]; m_b = bmag_q[31:0];  end
            2'd2: begin m_a = amag_q[31:0];  m_b = bmag_q[63:32]; end
            2'd3: begin m_a = amag_q[63:32]; m_b = bmag_q[63:32]; end
            default: ;
         endcase
      end
   end

   // Shifted returning partial product
   always_comb begin
      unique case (pend_slot_q)
         2'd0:    shamt = 7'd0;
         2'd3:    shamt = 7'd64;
         default: shamt = 7'd32;
      endcase
      addend = {64'd0, m_p} << shamt;
   end

   // Final signed product and per-op result selection
   always_comb begin
      prod = sign_q ? (~acc_q + 128'd1) : acc_q;
      unique case (op_q)
         OpMul:                      res = prod[63:0];
         OpMulh, OpMulhsu, OpMulhu:  res = prod[127:64];
         OpMulw:                     res = {{32{prod[31]}}, prod[31:0]};
         default:                    res = 64'd0;
      endcase
   end

   // flush in the DONE cycle cancels the pulse and leaves c_o at its old value
   assign done_o = (state_q == StDone) && !flush;
   assign c_o    = done_o ? res : c_q;

   // Next-state logic
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      op_d        = op_q;
      sign_d      = sign_q;
      amag_d      = amag_q;
      bmag_d      = bmag_q;
      acc_d       = acc_q;
      pend_d      = issuing && !flush;
      pend_slot_d = slot_q;
      c_d         = done_o ? res : c_q;

      // A returning product is only counted if its issue was not flushed
      if (pend_q) begin
         acc_d = acc_q + addend;
      end

      unique case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
         end
         StIssue: begin
            if (slot_q == last_slot) begin
               state_d = StDrain;
            end else begin
               slot_d = slot_q + 2'd1;
            end
         end
         StDrain: begin
            state_d = StDone;
         end
         default: state_d = StIdle;
      endcase

      if (accept) begin
         state_d = StIssue;
         slot_d  = 2'd0;
         op_d    = op_i;
         sign_d  = a_neg ^ b_neg;
         amag_d  = a_mag;
         bmag_d  = b_mag;
         acc_d   = 128'd0;
         pend_d  = 1'b0;
      end

      if (flush) begin
         state_d = StIdle;
         pend_d  = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         slot_q      <= 2'd0;
         op_q        <= 3'd0;
         sign_q      <= 1'b0;
         amag_q      <= 64'd0;
         bmag_q      <= 64'd0;
         acc_q       <= 128'd0;
         pend_q      <= 1'b0;
         pend_slot_q <= 2'd0;
         c_q         <= 64'd0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         op_q        <= op_d;
         sign_q      <= sign_d;
         amag_q      <= amag_d;
         bmag_q      <= bmag_d;
         acc_q       <= acc_d;
         pend_q      <= pend_d;
         pend_slot_q <= pend_slot_d;
         c_q         <= c_d;
      end
   end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: directed and randomized checks of mul_sequencer against a
// 128-bit arithmetic reference model.
module tb_mul_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        valid_i;
   logic [2:0]  op_i;
   logic [63:0] a_i, b_i;
   logic        flush;
   logic        ready_o, done_o;
   logic [63:0] c_o;
   logic [31:0] m_a, m_b;
   logic [63:0] m_p;

   int checks = 0;
   int passes = 0;

   mul_sequencer dut (
      .clk     (clk),
      .reset   (reset),
      .valid_i (valid_i),
      .op_i    (op_i),
      .a_i     (a_i),
      .b_i     (b_i),
      .flush   (flush),
      .ready_o (ready_o),
      .done_o  (done_o),
      .c_o     (c_o),
      .m_a     (m_a),
      .m_b     (m_b),
      .m_p     (m_p)
   );

   always #5 clk = ~clk;

   // External multiplier with one cycle of latency
   always @(posedge clk) m_p <= {32'd0, m_a} * {32'd0, m_b};

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs === exp) passes++;
      else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: full-width product of sign- or zero-extended operands
   function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                         input logic [63:0] b);
      logic [127:0] ea, eb, p;
      ea = {64'd0, a};
      eb = {64'd0, b};
      if (op == 3'd1 || op == 3'd2) ea = {{64{a[63]}}, a};
      if (op == 3'd1) eb = {{64{b[63]}}, b};
      p = ea * eb;
      case (op)
         3'd0:             return p[63:0];
         3'd1, 3'd2, 3'd3: return p[127:64];
         3'd4:             return {{32{p[31]}}, p[31:0]};
         default:          return 64'd0;
      endcase
   endfunction

   function automatic int latency(input logic [2:0] op);
      if (op == 3'd4) return 4;
      if (op == 3'd0) return 5;
      if (op <= 3'd3) return 6;
      return -1;
   endfunction

   function automatic logic [63:0] rand_operand();
      case ($urandom_range(0, 4))
         0:       return 64'h8000_0000_0000_0000;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return {{48{1'b0}}, 16'($urandom)};
         3:       return -64'($urandom_range(1, 1000));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   // Present a request in the current cycle; returns in the cycle after the accept edge
   task automatic start_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
      check("ready_before_accept", {63'd0, ready_o}, 64'd1);
      valid_i = 1'b1;
      op_i    = op;
      a_i     = a;
      b_i     = b;
      tick();
      valid_i = 1'b0;
      a_i     = $urandom;
      b_i     = $urandom;
   endtask

   // n0 = cycles since accept at entry; returns still inside the done cycle
   task automatic wait_done(input string tag, input int n0, input int lat,
                            input logic [63:0] exp);
      int n = n0;
      while (!done_o && n < 20) begin
         tick();
         n++;
      end
      check({tag, ".done"}, {63'd0, done_o}, 64'd1);
      if (lat > 0) check({tag, ".latency"}, 64'(n), 64'(lat));
      check({tag, ".c"}, c_o, exp);
   endtask

   task automatic watch_no_done(input string tag, input int cycles);
      int pulses = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (done_o) pulses++;
      end
      check(tag, 64'(pulses), 64'd0);
   endtask

   initial begin
      logic [2:0]  rop;
      logic [63:0] ra, rb, last_c;
      reset   = 1'b1;
      valid_i = 1'b0;
      flush   = 1'b0;
      op_i    = 3'd0;
      a_i     = 64'd0;
      b_i     = 64'd0;
      tick();
      tick();
      check("rst.ready", {63'd0, ready_o}, 64'd1);
      check("rst.done", {63'd0, done_o}, 64'd0);
      check("rst.c", c_o, 64'd0);
      check("rst.m", {m_a, m_b}, 64'd0);
      reset = 1'b0;

      // MUL 3*5 right after reset release
      start_op(3'd0, 64'd3, 64'd5);
      check("mul.m_t1", {m_a, m_b}, {32'd3, 32'd5});
      tick();
      check("mul.m_t2", {m_a, m_b}, {32'd0, 32'd5});
      tick();
      tick();
      check("mul.m_drain", {m_a, m_b}, 64'd0);
      wait_done("mul35", 4, 5, 64'd15);
      tick();
      check("mul.pulse_len", {63'd0, done_o}, 64'd0);
      check("mul.c_hold", c_o, 64'd15);

      start_op(3'd1, 64'h8000_0000_0000_0000, 64'd2);
      wait_done("mulh_min", 1, 6, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      start_op(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("mulh_m1", 1, 6, 64'd0);
      tick();
      start_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      wait_done("mulhu_max", 1, 6, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      start_op(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
      wait_done("mulhsu", 1, 6, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();

      // MULW followed by a back-to-back MULW accepted in the done cycle
      start_op(3'd4, 64'h7FFF_FFFF, 64'd2);
      wait_done("mulw", 1, 4, 64'hFFFF_FFFF_FFFF_FFFE);
      start_op(3'd4, 64'd1, 64'd1);
      wait_done("mulw_b2b", 1, 4, 64'd1);
      tick();
      check("mulw_b2b.pulse_len", {63'd0, done_o}, 64'd0);

      // Flush a MULHU at T+3, then a MUL must ignore the stale product
      start_op(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      tick();
      flush = 1'b1;
      check("flush.done_t3", {63'd0, done_o}, 64'd0);
      tick();
      flush = 1'b0;
      check("flush.ready_t4", {63'd0, ready_o}, 64'd1);
      check("flush.done_t4", {63'd0, done_o}, 64'd0);
      check("flush.c_hold", c_o, 64'd1);
      start_op(3'd0, 64'd7, 64'd7);
      wait_done("after_flush", 1, 5, 64'd49);
      tick();

      // flush together with valid: no accept
      valid_i = 1'b1;
      flush   = 1'b1;
      op_i    = 3'd0;
      a_i     = 64'd9;
      b_i     = 64'd9;
      tick();
      valid_i = 1'b0;
      flush   = 1'b0;
      check("flush_valid.ready", {63'd0, ready_o}, 64'd1);
      watch_no_done("flush_valid.no_done", 8);

      // Reset mid MULH
      start_op(3'd1, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
      tick();
      reset = 1'b1;
      #1;
      check("rst_mid.ready", {63'd0, ready_o}, 64'd1);
      check("rst_mid.done", {63'd0, done_o}, 64'd0);
      check("rst_mid.c", c_o, 64'd0);
      check("rst_mid.m", {m_a, m_b}, 64'd0);
      tick();
      reset = 1'b0;
      watch_no_done("rst_mid.no_done", 10);

      // Randomized ops, some back-to-back from the done cycle
      for (int i = 0; i < 60; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = rand_operand();
         rb  = rand_operand();
         start_op(rop, ra, rb);
         last_c = model(rop, ra, rb);
         wait_done($sformatf("rand%0d_op%0d", i, rop), 1, latency(rop), last_c);
         if ($urandom_range(0, 1) == 0) begin
            tick();
            check("rand.pulse_len", {63'd0, done_o}, 64'd0);
            check("rand.c_hold", c_o, last_c);
         end
      end
      tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
